cursor_report_sched: RTL and testbench
======================================

# cursor_report_sched

Paces cursor motion into fixed-rate 5-byte mouse reports for the host link. Sits between the cursor mapper, which produces per-sample signed `dx`/`dy` and the safety `tier`, and the byte-serial transmitter (UART/HID bridge). The block:
- accumulates motion between report slots with saturation;
- merges click requests into press/release report pairs;
- serialises each report over a valid/ready byte handshake;
- suppresses all new activity while the safety tier is high.

## Interface
Parameters:
- PERIOD, 24'd100000, clock cycles between report slots (≥ 8)
- HDR, 8'hA5, report header byte
- AMAX, 8'sd127, accumulator saturation magnitude (symmetric ±AMAX)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  dx/dy sample strobe from cursor mapper
- dx  in  8 signed  x motion sample
- dy  in  8 signed  y motion sample
- tier  in  2  safety tier; ≥2 = inhibit
- click_req  in  1  single-cycle click request
- tx_data  out  8  report byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  report in flight
- overflow  out  1  sticky; set when an accumulator saturated, cleared at next report start

## Operation
- Accumulators acc_x/acc_y: signed 8-bit. Each in_valid adds dx/dy using a 10-bit intermediate, then clamps to [-AMAX, +AMAX]. Clamping sets overflow.
- Slot counter: counts 0..PERIOD-1 and asserts tick at PERIOD-1, free-running. A tick while busy sets tick_pend (single-deep). The pending tick is consumed on return to IDLE.
- Report trigger, on tick or tick_pend in IDLE with tier<2, when any of: acc_x≠0, acc_y≠0, press_pend, release_pend.
- If nothing is pending, the tick is discarded.
- At report start:
  - snapshot btn/acc into shadow registers;
  - clear acc_x/acc_y; an in_valid in the same cycle loads into the cleared accumulators, no sample lost;
  - clear overflow.
- Button byte:
  - if press_pend: btn=1, clear press_pend, set release_pend;
  - else if release_pend: btn=0, clear release_pend;
  - otherwise btn=0.
- click_req sets press_pend. A click_req while press_pend is already set is absorbed: one press per report.
- Report bytes in order: HDR, {7'b0,btn}, dx_snap, dy_snap, checksum = byte1^byte2^byte3.
- FSM states: IDLE → HDR → BTN → DX → DY → SUM → IDLE. Each non-IDLE state drives tx_valid=1 with constant tx_data, and advances only on tx_valid&tx_ready.
- busy = (state≠IDLE).
- Inhibit (tier≥2):
  - accumulators held at 0 and in_valid ignored;
  - click_req ignored, press_pend/release_pend/tick_pend cleared;
  - no new report starts;
  - a report already in flight completes unchanged.
- Exception to inhibit: if release_pend was set when tier rose, one release report (btn=0, dx=dy=0) is still sent at the next tick, so the host never sees a stuck button.

## Timing
- Reset values: tx_valid=0, tx_data=0, busy=0, overflow=0, state IDLE, counter=0, acc/pend flags 0.
- Reset mid-report aborts immediately: tx_valid drops asynchronously and the partial report is not resumed.
- tx_valid and the HDR byte rise on the first clock edge after the tick cycle.
- Minimum report length is 5 cycles with tx_ready held high; back-pressure stretches any byte indefinitely.
- tx_data is registered and must not change while tx_valid=1 and tx_ready=0.
- in_valid and the report-start snapshot in the same cycle: the snapshot takes the pre-add value, and the new sample goes to the next report.
- tier is sampled at the clock edge. A tier change takes effect on the same edge for accumulate and trigger decisions.

## Structure
- Shared package cursor_pkg:
  - state enum {IDLE,HDR,BTN,DX,DY,SUM};
  - REPORT_LEN=5;
  - TIER_INHIBIT=2;
  - saturating-add function sat_add8(acc,delta,amax), also reusable by cursor_map.
- One sub-module: cursor_slot_timer (PERIOD counter + tick). The FSM and accumulators stay in the top.

## Test plan
- PERIOD=16, in_valid with dx=+5,dy=-3 ×4 then quiet, tx_ready=1 → one report A5,00,14,F4,E0; no further report at later ticks.
- 30 samples dx=+10 → acc_x clamps at 7F, overflow=1; report byte2=7F, overflow cleared at report start.
- click_req pulse, no motion → two consecutive slot reports: A5,01,00,00,01 then A5,00,00,00,00.
- tx_ready low 40 cycles during DX byte → tx_valid/tx_data stable; one deferred report at return to IDLE, not two.
- tier=2 after press report, with motion and clicks applied → only the release report A5,00,00,00,00 is sent; accumulators stay 0; nothing sent until tier<2 and new motion.
- rst_n low during BTN byte → tx_valid=0 immediately; after release, the next report starts with HDR.

Source files
------------

// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - shared types, constants and saturating add for the cursor pipeline
// Contents:
//   state_t      report serialiser states
//   REPORT_LEN   bytes per mouse report
//   TIER_INHIBIT safety tier at or above which new activity is suppressed
//   sat_add8     signed 8-bit add clamped to [-amax, +amax], with a saturation flag
package cursor_pkg;

  // HDR is also a parameter name in the scheduler, so states carry an ST_ prefix.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BTN,
    ST_DX,
    ST_DY,
    ST_SUM
  } state_t;

  localparam int          REPORT_LEN   = 5;
  localparam logic [1:0]  TIER_INHIBIT = 2'd2;

  typedef struct packed {
    logic [7:0] val;
    logic       sat;
  } sat_t;

  // 10-bit intermediate so that two 8-bit signed operands can never wrap
  // before the clamp is applied.
  function automatic sat_t sat_add8(input logic signed [7:0] acc,
                                    input logic signed [7:0] delta,
                                    input logic signed [7:0] amax);
    logic signed [9:0] sum;
    logic signed [9:0] hi;
    logic signed [9:0] lo;
    sat_t              r;
    sum   = 10'(acc) + 10'(delta);
    hi    = 10'(amax);
    lo    = -hi;
    r.val = sum[7:0];
    r.sat = 1'b0;
    if (sum > hi) begin
      r.val = hi[7:0];
      r.sat = 1'b1;
    end else if (sum < lo) begin
      r.val = lo[7:0];
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cursor_report_sched_if.sv
// rtl/cursor_report_sched_if.sv - byte-serial report stream towards the host transmitter
// Signals:
//   tx_data   report byte
//   tx_valid  tx_data valid
//   tx_ready  transmitter accepts byte
// Modports: master (report scheduler), slave (transmitter)
interface cursor_report_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cursor_slot_timer.sv
// rtl/cursor_slot_timer.sv - free-running report slot counter
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tick        high for one cycle when the counter is at PERIOD-1
module cursor_slot_timer #(
  parameter logic [23:0] PERIOD = 24'd100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [23:0] cnt;

  assign tick = (cnt == PERIOD - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/cursor_report_sched.sv
// rtl/cursor_report_sched.sv - paces cursor motion and clicks into 5-byte host reports
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     dx/dy sample strobe
//   dx, dy       signed motion samples
//   tier         safety tier; >= TIER_INHIBIT suppresses new activity
//   click_req    single-cycle click request
//   tx           report byte stream (master side)
//   busy         report in flight
//   overflow     sticky accumulator saturation, cleared at report start
module cursor_report_sched
  import cursor_pkg::*;
#(
  parameter logic [23:0]       PERIOD = 24'd100000,
  parameter logic [7:0]        HDR    = 8'hA5,
  parameter logic signed [7:0] AMAX   = 8'sd127
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [7:0]    dx,
  input  logic signed [7:0]    dy,
  input  logic [1:0]           tier,
  input  logic                 click_req,
  cursor_report_sched_if.master tx,
  output logic                 busy,
  output logic                 overflow
);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        data_q;
  logic [7:0]        data_nx;
  logic              valid_q;

  logic              tick;
  logic              inhibit;
  logic              tick_any;
  logic              has_work;
  logic              start;

  logic signed [7:0] acc_x;
  logic signed [7:0] acc_y;
  logic signed [7:0] base_x;
  logic signed [7:0] base_y;
  sat_t              sx;
  sat_t              sy;

  logic              press_pend;
  logic              release_pend;
  logic              tick_pend;
  // Remembers that a release was owed when the tier went high, so the host
  // still gets its button-up report while everything else is suppressed.
  logic              rel_hold;

  logic              btn_s;
  logic [7:0]        dx_s;
  logic [7:0]        dy_s;

  cursor_slot_timer #(.PERIOD(PERIOD)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign inhibit  = (tier >= TIER_INHIBIT);
  assign tick_any = tick | (tick_pend & ~inhibit);
  assign has_work = (acc_x != 8'sd0) | (acc_y != 8'sd0) | press_pend | release_pend;
  assign start    = (state == ST_IDLE) & tick_any & ((~inhibit & has_work) | rel_hold);

  assign busy        = (state != ST_IDLE);
  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = data_q;

  always_comb begin
    state_nx = state;
    data_nx  = 8'h00;
    case (state)
      ST_IDLE: if (start)                       state_nx = ST_HDR;
      ST_HDR:  if (valid_q && tx.tx_ready)      state_nx = ST_BTN;
      ST_BTN:  if (valid_q && tx.tx_ready)      state_nx = ST_DX;
      ST_DX:   if (valid_q && tx.tx_ready)      state_nx = ST_DY;
      ST_DY:   if (valid_q && tx.tx_ready)      state_nx = ST_SUM;
      ST_SUM:  if (valid_q && tx.tx_ready)      state_nx = ST_IDLE;
      default:                                  state_nx = ST_IDLE;
    endcase
    // The byte register is loaded from the state being entered, so it only
    // changes on an accepted handshake and holds under back-pressure.
    case (state_nx)
      ST_HDR:  data_nx = HDR;
      ST_BTN:  data_nx = {7'b0, btn_s};
      ST_DX:   data_nx = dx_s;
      ST_DY:   data_nx = dy_s;
      ST_SUM:  data_nx = {7'b0, btn_s} ^ dx_s ^ dy_s;
      default: data_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      data_q  <= data_nx;
      valid_q <= (state_nx != ST_IDLE);
    end
  end

  // A sample arriving in the report-start cycle lands in the freshly cleared
  // accumulator; the snapshot below still sees the pre-add value.
  assign base_x = start ? 8'sd0 : acc_x;
  assign base_y = start ? 8'sd0 : acc_y;

  always_comb begin
    sx = sat_add8(base_x, dx, AMAX);
    sy = sat_add8(base_y, dy, AMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x    <= 8'sd0;
      acc_y    <= 8'sd0;
      overflow <= 1'b0;
    end else begin
      if (inhibit) begin
        acc_x <= 8'sd0;
        acc_y <= 8'sd0;
      end else if (in_valid) begin
        acc_x <= sx.val;
        acc_y <= sy.val;
      end else if (start) begin
        acc_x <= 8'sd0;
        acc_y <= 8'sd0;
      end
      if (!inhibit && in_valid && (sx.sat || sy.sat)) begin
        overflow <= 1'b1;
      end else if (start) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s <= 1'b0;
      dx_s  <= 8'h00;
      dy_s  <= 8'h00;
    end else if (start) begin
      btn_s <= ~inhibit & press_pend;
      dx_s  <= inhibit ? 8'h00 : acc_x;
      dy_s  <= inhibit ? 8'h00 : acc_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend   <= 1'b0;
      release_pend <= 1'b0;
      tick_pend    <= 1'b0;
      rel_hold     <= 1'b0;
    end else if (inhibit) begin
      press_pend   <= 1'b0;
      release_pend <= 1'b0;
      tick_pend    <= 1'b0;
      if (release_pend) begin
        rel_hold <= 1'b1;
      end else if (start) begin
        rel_hold <= 1'b0;
      end
    end else begin
      if (start && press_pend) begin
        press_pend <= click_req;
      end else if (click_req) begin
        press_pend <= 1'b1;
      end
      if (start) begin
        release_pend <= press_pend;
        rel_hold     <= 1'b0;
      end
      if (tick && (state != ST_IDLE)) begin
        tick_pend <= 1'b1;
      end else if (state == ST_IDLE) begin
        tick_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cursor_report_sched.sv
// tb/tb_cursor_report_sched.sv - directed self-checking bench for cursor_report_sched
module tb_cursor_report_sched;

  localparam int P = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] dx = 8'sd0;
  logic signed [7:0] dy = 8'sd0;
  logic [1:0]        tier = 2'd0;
  logic              click_req = 1'b0;
  logic              busy;
  logic              overflow;

  cursor_report_sched_if txi();

  cursor_report_sched #(
    .PERIOD (24'd16),
    .HDR    (8'hA5),
    .AMAX   (8'sd127)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dx        (dx),
    .dy        (dy),
    .tier      (tier),
    .click_req (click_req),
    .tx        (txi),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (txi.tx_valid && !prev_v) start_q.push_back(cyc);
      if (txi.tx_valid && txi.tx_ready) rx_q.push_back(txi.tx_data);
    end
    prev_v = txi.tx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    bit ok = 1'b0;
    for (int k = 0; k < 4 * P; k++) begin
      step();
      if ((cyc % P) == p) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 4 * P; k++) begin
      step();
      if (txi.tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic sample(input logic signed [7:0] x, input logic signed [7:0] y);
    in_valid = 1'b1;
    dx = x;
    dy = y;
    step();
    in_valid = 1'b0;
    dx = 8'sd0;
    dy = 8'sd0;
  endtask

  task automatic click();
    click_req = 1'b1;
    step();
    click_req = 1'b0;
  endtask

  task automatic expect_report(input string tag, input logic [39:0] exp);
    if (rx_q.size() < 5) begin
      chk({tag, "_len"}, rx_q.size(), 32'd5);
      rx_q.delete();
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0] b;
        b = rx_q.pop_front();
        chk($sformatf("%s_b%0d", tag, i), b, exp[39 - 8 * i -: 8]);
      end
    end
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, "_extra_bytes"}, rx_q.size(), 32'd0);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s1;
    int s2;
    int bad;
    txi.tx_ready = 1'b1;

    #2;
    chk("rst_valid", txi.tx_valid, 32'd0);
    chk("rst_data", txi.tx_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    #10 rst_n = 1'b1;

    // Accumulated motion, single report, no repeat on later empty slots.
    clear_mon();
    wait_phase(0);
    repeat (4) sample(8'sd5, -8'sd3);
    repeat (3 * P) step();
    expect_report("t1", 40'hA5_00_14_F4_E0);
    expect_empty("t1");
    if (start_q.size() > 0) chk("t1_start_phase", start_q[0] % P, 32'd0);
    else chk("t1_start_seen", 32'd0, 32'd1);

    // Saturation, overflow lifetime, sample coinciding with report start.
    clear_mon();
    wait_phase(0);
    repeat (13) sample(8'sd10, 8'sd0);
    chk("t2_ovf_set", overflow, 32'd1);
    step();
    step();
    sample(8'sd3, 8'sd0);
    chk("t2_busy", busy, 32'd1);
    chk("t2_ovf_clr", overflow, 32'd0);
    chk("t2_hdr_byte", txi.tx_data, 32'hA5);
    repeat (3 * P) step();
    expect_report("t2a", 40'hA5_00_7F_00_7F);
    expect_report("t2b", 40'hA5_00_03_00_03);
    expect_empty("t2");

    // Click becomes press then release in consecutive slots; second click absorbed.
    clear_mon();
    wait_phase(0);
    click();
    step();
    click();
    repeat (4 * P) step();
    expect_report("t3p", 40'hA5_01_00_00_01);
    expect_report("t3r", 40'hA5_00_00_00_00);
    expect_empty("t3");
    if (start_q.size() == 2) chk("t3_slot_gap", start_q[1] - start_q[0], 32'd16);
    else chk("t3_starts", start_q.size(), 32'd2);

    // Back-pressure on the DX byte, ticks during the stall collapse into one.
    clear_mon();
    wait_phase(0);
    sample(8'sd1, 8'sd0);
    wait_valid("t4");
    step();
    step();
    txi.tx_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        dx = 8'sd2;
      end else begin
        in_valid = 1'b0;
        dx = 8'sd0;
      end
      step();
      if (!txi.tx_valid || txi.tx_data !== 8'h01) bad++;
    end
    in_valid = 1'b0;
    dx = 8'sd0;
    chk("t4_stall_stable", bad, 32'd0);
    txi.tx_ready = 1'b1;
    repeat (3 * P) step();
    expect_report("t4a", 40'hA5_00_01_00_01);
    expect_report("t4b", 40'hA5_00_02_00_02);
    expect_empty("t4");
    if (start_q.size() == 2) chk("t4_deferred_gap", start_q[1] - start_q[0], 32'd46);
    else chk("t4_starts", start_q.size(), 32'd2);

    // Inhibit after a press: only the owed release goes out.
    clear_mon();
    wait_phase(0);
    click();
    repeat (P + 8) step();
    chk("t5_idle", busy, 32'd0);
    expect_report("t5p", 40'hA5_01_00_00_01);
    tier = 2'd2;
    for (int i = 0; i < 3 * P; i++) begin
      in_valid = 1'b1;
      dx = 8'sd7;
      dy = -8'sd2;
      click_req = ((i % 4) == 0);
      step();
    end
    chk("t5_acc_x_held", dut.acc_x, 32'd0);
    chk("t5_acc_y_held", dut.acc_y, 32'd0);
    in_valid = 1'b0;
    dx = 8'sd0;
    dy = 8'sd0;
    click_req = 1'b0;
    tier = 2'd0;
    expect_report("t5r", 40'hA5_00_00_00_00);
    expect_empty("t5_inh");
    repeat (2 * P) step();
    expect_empty("t5_quiet");
    sample(8'sd4, 8'sd0);
    repeat (2 * P) step();
    expect_report("t5n", 40'hA5_00_04_00_04);
    expect_empty("t5");

    // Reset during the BTN byte aborts the report.
    clear_mon();
    wait_phase(0);
    sample(8'sd1, 8'sd0);
    wait_valid("t6");
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", txi.tx_valid, 32'd0);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_data", txi.tx_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    step();
    sample(8'sd6, 8'sd0);
    repeat (2 * P) step();
    expect_report("t6", 40'hA5_00_06_00_06);
    expect_empty("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
